// File: rtl/xpb_pkg.sv
// Shared definitions for the xpb reduction accumulator: word/digit widths,
// FSM state encoding and the result-width helper.
package xpb_pkg;

  localparam int unsigned WORD_W  = 1024;
  localparam int unsigned DIGIT_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } xpb_state_e;

  // Result width: base word plus headroom for NUM_DIGITS table words.
  function automatic int unsigned sum_w(input int unsigned word_w,
                                        input int unsigned num_digits);
    return word_w + $clog2(num_digits + 1);
  endfunction

endpackage

// File: rtl/xpb_reduce_accum.sv
// Serial xpb reduction: adds one external table word per upper 5-bit digit to
// the base value. Optional early termination via `define XPB_ACC_EARLY_EXIT_EN.
module xpb_reduce_accum #(
  parameter  int unsigned NUM_DIGITS = 4,
  parameter  int unsigned WORD_W     = xpb_pkg::WORD_W,
  localparam int unsigned SUM_W      = xpb_pkg::sum_w(WORD_W, NUM_DIGITS),
  localparam int unsigned SEL_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int unsigned HI_W       = xpb_pkg::DIGIT_W * NUM_DIGITS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_lo,
  input  logic [HI_W-1:0]   in_hi,
  output logic [SEL_W-1:0]  lut_digit,
  output logic [4:0]        lut_sel,
  input  logic [WORD_W-1:0] lut_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SUM_W-1:0]  out_data
);

  import xpb_pkg::*;

  xpb_state_e        state_q, state_d;
  logic [SUM_W-1:0]  acc_q, acc_d;
  logic [HI_W-1:0]   shreg_q, shreg_d;
  logic [SEL_W-1:0]  cnt_q, cnt_d;
  logic              last_digit;
  logic              skip_rest;

  always_comb begin
    last_digit = (cnt_q == SEL_W'(NUM_DIGITS - 1));
`ifdef XPB_ACC_EARLY_EXIT_EN
    // All remaining digits are zero: their table words would add nothing.
    skip_rest  = (shreg_q == '0);
`else
    skip_rest  = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_d   = SUM_W'(in_lo);
          shreg_d = in_hi;
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (skip_rest) begin
          state_d = DONE;
        end else begin
          acc_d   = acc_q + SUM_W'(lut_data);
          shreg_d = shreg_q >> DIGIT_W;
          cnt_d   = cnt_q + SEL_W'(1);
          if (last_digit) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Table address is gated by state so the external LUT sees 0 when idle.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    out_data  = acc_q;
    lut_sel   = '0;
    lut_digit = '0;
    if (state_q == ACCUM) begin
      lut_sel   = shreg_q[4:0];
      lut_digit = cnt_q;
    end
  end

endmodule

// File: tb/tb_xpb_reduce_accum.sv
// Directed bench for xpb_reduce_accum with a scoreboard of expected results
// and a behavioural LUT: lut_data = (lut_digit+1) * lut_sel.
module tb_xpb_reduce_accum;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned WORD_W     = 1024;
  localparam int unsigned SUM_W      = WORD_W + $clog2(NUM_DIGITS + 1);
  localparam int unsigned SEL_W      = $clog2(NUM_DIGITS);
  localparam int unsigned HI_W       = 5 * NUM_DIGITS;
`ifdef XPB_ACC_EARLY_EXIT_EN
  localparam int ZERO_HI_LAT = 2;
`else
  localparam int ZERO_HI_LAT = NUM_DIGITS + 1;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_lo;
  logic [HI_W-1:0]   in_hi;
  logic [SEL_W-1:0]  lut_digit;
  logic [4:0]        lut_sel;
  logic [WORD_W-1:0] lut_data;
  logic              out_valid;
  logic              out_ready;
  logic [SUM_W-1:0]  out_data;

  int vectors     = 0;
  int miscompares = 0;
  int n_accept    = 0;
  int cyc         = 0;
  logic [SUM_W-1:0] sb[$];
  int               acc_cyc[$];

  xpb_reduce_accum #(.NUM_DIGITS(NUM_DIGITS), .WORD_W(WORD_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_lo(in_lo), .in_hi(in_hi),
    .lut_digit(lut_digit), .lut_sel(lut_sel), .lut_data(lut_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  always_comb lut_data = WORD_W'((int'(lut_digit) + 1) * int'(lut_sel));

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [SUM_W-1:0] obs,
                       input logic [SUM_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [SUM_W-1:0] model(input logic [WORD_W-1:0] lo,
                                             input logic [HI_W-1:0] hi);
    logic [SUM_W-1:0] r;
    r = SUM_W'(lo);
    for (int k = 0; k < NUM_DIGITS; k++)
      r = r + SUM_W'((k + 1) * int'(hi[5*k +: 5]));
    return r;
  endfunction

  // Output monitor: pops the scoreboard on each result handshake, logs accepts.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) check("unexpected_result", SUM_W'(1), SUM_W'(0));
      else                check("result", out_data, sb.pop_front());
    end
    if (rst_n && in_valid && in_ready) begin
      n_accept++;
      acc_cyc.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers an operand and returns just after the accepting edge.
  task automatic send_op(input logic [WORD_W-1:0] lo, input logic [HI_W-1:0] hi,
                         input bit keep_valid);
    int t;
    in_lo    = lo;
    in_hi    = hi;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 50) begin
      step();
      t++;
    end
    if (!in_ready) check("accept_timeout", SUM_W'(0), SUM_W'(1));
    step();
    sb.push_back(model(lo, hi));
    if (!keep_valid) in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int exp_lat, input string tag);
    int lat;
    lat = 1;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
    end
    check(tag, SUM_W'(lat), SUM_W'(exp_lat));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [SUM_W-1:0] exp;
    int base;
    int t;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_lo = '0; in_hi = '0;
    step(); step(); step();
    check("rst_in_ready",  SUM_W'(in_ready),  SUM_W'(1));
    check("rst_out_valid", SUM_W'(out_valid), SUM_W'(0));
    check("rst_lut_sel",   SUM_W'(lut_sel),   SUM_W'(0));
    check("rst_lut_digit", SUM_W'(lut_digit), SUM_W'(0));
    check("rst_out_data",  out_data,          SUM_W'(0));
    rst_n = 1'b1;
    step();

    // All digits 1: table index/digit sequence and 5-cycle latency.
    send_op(WORD_W'(32'h10), HI_W'(20'h08421), 1'b0);
    for (int j = 0; j < NUM_DIGITS; j++) begin
      check("lut_digit_seq", SUM_W'(lut_digit), SUM_W'(j));
      check("lut_sel_seq",   SUM_W'(lut_sel),   SUM_W'(1));
      step();
    end
    check("lat_digits1",  SUM_W'(out_valid), SUM_W'(1));
    check("data_digits1", out_data,          SUM_W'(32'h1A));
    step();
    check("idle_in_ready",  SUM_W'(in_ready), SUM_W'(1));
    check("idle_lut_sel",   SUM_W'(lut_sel),  SUM_W'(0));
    check("idle_hold_data", out_data,         SUM_W'(32'h1A));

    // Maximum operand: carry into the headroom bits.
    send_op('1, '1, 1'b0);
    wait_valid(NUM_DIGITS + 1, "lat_max");
    check("max_top_bits", SUM_W'(out_data[SUM_W-1:WORD_W]), SUM_W'(1));
    check("max_low_bits", SUM_W'(out_data[WORD_W-1:0]),     SUM_W'(309));
    step();

    // No upper digits.
    send_op(WORD_W'(32'h5), '0, 1'b0);
    wait_valid(ZERO_HI_LAT, "lat_zero_hi");
    check("data_zero_hi", out_data, SUM_W'(32'h5));
    step();

    // Back-pressure for 7 cycles, then release with a new operand waiting.
    out_ready = 1'b0;
    send_op(WORD_W'(32'h123), HI_W'(20'h92345), 1'b0);
    exp = model(WORD_W'(32'h123), HI_W'(20'h92345));
    wait_valid(NUM_DIGITS + 1, "lat_stall");
    for (int i = 0; i < 7; i++) begin
      check("stall_valid", SUM_W'(out_valid), SUM_W'(1));
      check("stall_ready", SUM_W'(in_ready),  SUM_W'(0));
      check("stall_data",  out_data,          exp);
      step();
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_lo     = WORD_W'(32'h7);
    in_hi     = HI_W'(20'h80003);
    base      = n_accept;
    step();
    check("release_no_accept", SUM_W'(n_accept), SUM_W'(base));
    check("release_in_ready",  SUM_W'(in_ready), SUM_W'(1));
    step();
    in_valid = 1'b0;
    sb.push_back(model(WORD_W'(32'h7), HI_W'(20'h80003)));
    check("release_next_accept", SUM_W'(n_accept), SUM_W'(base + 1));
    wait_valid(NUM_DIGITS + 1, "lat_after_stall");
    step();

    // Reset during the third ACCUM cycle discards the operation.
    send_op(WORD_W'(32'h99), HI_W'(20'hFFFFF), 1'b0);
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    check("midrst_out_valid", SUM_W'(out_valid), SUM_W'(0));
    check("midrst_in_ready",  SUM_W'(in_ready),  SUM_W'(1));
    check("midrst_lut_digit", SUM_W'(lut_digit), SUM_W'(0));
    check("midrst_acc",       out_data,          SUM_W'(0));
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("postrst_no_valid", SUM_W'(out_valid), SUM_W'(0));
      step();
    end
    check("postrst_in_ready", SUM_W'(in_ready), SUM_W'(1));
    send_op(WORD_W'(32'hABC), HI_W'(20'h7A5C3), 1'b0);
    wait_valid(NUM_DIGITS + 1, "lat_postrst");
    step();

    // Back-to-back with in_valid held high.
    acc_cyc.delete();
    base = n_accept;
    for (int i = 0; i < 4; i++)
      send_op(WORD_W'(1000 * (i + 1)), HI_W'(20'h84000 + 20'h00421 * i), 1'b1);
    in_valid = 1'b0;
    t = 0;
    while (sb.size() != 0 && t < 100) begin
      step();
      t++;
    end
    check("b2b_drain",   SUM_W'(sb.size()), SUM_W'(0));
    check("b2b_accepts", SUM_W'(n_accept - base), SUM_W'(4));
    for (int i = 1; i < 4; i++)
      if (i < acc_cyc.size())
        check("b2b_interval", SUM_W'(acc_cyc[i] - acc_cyc[i-1]), SUM_W'(NUM_DIGITS + 2));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
